ysyx_23060332_mem_arbiter: RTL

Two-master, one-slave arbiter that shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Serialises accesses with valid/ready handshakes and allows one outstanding transaction at a time.
- Round-robin on conflict.
- Rejects LSU addresses outside the physical memory window locally, without touching memory.
- Sits between the IFU/LSU and the memory module; address alignment and byte lanes are passed through unchanged.

---
 rtl/ysyx_23060332_mem_arbiter_pkg.sv | 37 +++
 rtl/ysyx_23060332_rr_arb2.sv | 34 +++
 rtl/ysyx_23060332_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_mem_arbiter_pkg
// Shared definitions for the IFU/LSU data-memory arbiter:
//   - physical memory window (MEM_BASE .. MEM_LIMIT, inclusive)
//   - arbiter FSM state encoding (3-bit)
//   - transaction owner encoding (IFU = 0, LSU = 1)
//   - ZeroWord constant and the address-window helper
// ---------------------------------------------------------------------------
package ysyx_23060332_mem_arbiter_pkg;

    localparam logic [31:0] MEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] MEM_LIMIT = 32'h87ff_ffff;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    // True when addr lies inside the inclusive window [base, limit].
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/ysyx_23060332_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_rr_arb2
// Two-input round-robin picker.
//   req[1:0]    : request vector, bit 0 = IFU, bit 1 = LSU
//   last_grant  : owner that won the previous handshake (IFU = 0, LSU = 1)
//   grant[1:0]  : one-hot grant, 2'b00 when nobody requests
// A lone requester always wins; on a conflict the master that did not win
// last time is chosen, so neither side can starve.
// ---------------------------------------------------------------------------
module ysyx_23060332_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    import ysyx_23060332_mem_arbiter_pkg::*;

    // Grant selection: single requester wins, conflicts alternate.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant == OWNER_IFU) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_mem_arbiter
// Shares the single data-memory port between the IFU (read-only) and the
// LSU (read/write). One transaction is outstanding at a time; conflicts are
// resolved round-robin; addresses outside [MEM_BASE, MEM_LIMIT] are answered
// locally with an access fault and never reach memory.
//
// Ports
//   clk, rst                       : clock (rising edge), async active-high reset
//   ifu_req_valid/ready, ifu_addr  : IFU read request channel
//   ifu_resp_valid/rdata/err       : IFU response, resp_valid is a 1-cycle pulse
//   lsu_req_valid/ready, lsu_wen,
//   lsu_addr/wdata/wmask           : LSU request channel
//   lsu_resp_valid/rdata/err       : LSU response, rdata is 0 for writes
//   mem_req_valid/ready, mem_ren,
//   mem_wen, mem_addr/wdata/wmask  : request to the memory module
//   mem_resp_valid, mem_rdata      : memory response (read data / write ack)
// ---------------------------------------------------------------------------
module ysyx_23060332_mem_arbiter #(
    parameter logic [31:0] MEM_BASE  = ysyx_23060332_mem_arbiter_pkg::MEM_BASE,
    parameter logic [31:0] MEM_LIMIT = ysyx_23060332_mem_arbiter_pkg::MEM_LIMIT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);
    import ysyx_23060332_mem_arbiter_pkg::*;

    arb_state_e  state_r;
    arb_state_e  state_nxt_s;
    owner_e      last_grant_r;
    owner_e      owner_r;
    logic        wen_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [7:0]  wmask_r;
    logic [31:0] rdata_r;

    logic [1:0]  req_s;
    logic [1:0]  grant_s;
    logic        accept_s;
    owner_e      sel_owner_s;
    logic        sel_wen_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [7:0]  sel_wmask_s;

    assign req_s = {lsu_req_valid, ifu_req_valid};

    ysyx_23060332_rr_arb2 u_rr_arb2 (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Next-state logic and all outputs, decoded from the registered state.
    always_comb begin
        state_nxt_s    = state_r;
        accept_s       = 1'b0;
        sel_owner_s    = OWNER_IFU;
        sel_wen_s      = 1'b0;
        sel_addr_s     = ZeroWord;
        sel_wdata_s    = ZeroWord;
        sel_wmask_s    = 8'h00;

        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = ZeroWord;
        ifu_resp_err   = 1'b0;
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = ZeroWord;
        lsu_resp_err   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_addr       = ZeroWord;
        mem_wdata      = ZeroWord;
        mem_wmask      = 8'h00;

        case (state_r)
            ST_IDLE: begin
                // Ready is combinational here; it is held low while reset is
                // asserted so no handshake is advertised during reset.
                if (rst) begin
                    accept_s = 1'b0;
                end else if (grant_s[1]) begin
                    lsu_req_ready = 1'b1;
                    accept_s      = 1'b1;
                    sel_owner_s   = OWNER_LSU;
                    sel_wen_s     = lsu_wen;
                    sel_addr_s    = lsu_addr;
                    sel_wdata_s   = lsu_wdata;
                    sel_wmask_s   = lsu_wmask;
                end else if (grant_s[0]) begin
                    ifu_req_ready = 1'b1;
                    accept_s      = 1'b1;
                    sel_owner_s   = OWNER_IFU;
                    sel_addr_s    = ifu_addr;
                end else begin
                    accept_s = 1'b0;
                end

                if (accept_s) begin
                    if (addr_in_window(sel_addr_s, MEM_BASE, MEM_LIMIT)) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_ERR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_ren       = ~wen_r;
                mem_wen       = wen_r;
                mem_addr      = addr_r;
                mem_wdata     = wdata_r;
                mem_wmask     = wmask_r;
                if (mem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end

            ST_RESP: begin
                if (owner_r == OWNER_LSU) begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = rdata_r;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_rdata      = rdata_r;
                end
                state_nxt_s = ST_IDLE;
            end

            ST_ERR: begin
                if (owner_r == OWNER_LSU) begin
                    lsu_resp_valid = 1'b1;
                    lsu_resp_err   = 1'b1;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_resp_err   = 1'b1;
                end
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the winning request on handshake; fields stay frozen until the
    // next handshake so mem_* is stable for the whole REQ phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= OWNER_IFU;
            owner_r      <= OWNER_IFU;
            wen_r        <= 1'b0;
            addr_r       <= ZeroWord;
            wdata_r      <= ZeroWord;
            wmask_r      <= 8'h00;
        end else if (accept_s) begin
            last_grant_r <= sel_owner_s;
            owner_r      <= sel_owner_s;
            wen_r        <= sel_wen_s;
            addr_r       <= sel_addr_s;
            wdata_r      <= sel_wdata_s;
            wmask_r      <= sel_wmask_s;
        end else begin
            last_grant_r <= last_grant_r;
            owner_r      <= owner_r;
            wen_r        <= wen_r;
            addr_r       <= addr_r;
            wdata_r      <= wdata_r;
            wmask_r      <= wmask_r;
        end
    end

    // Capture the memory response only in WAIT; responses arriving in any
    // other state are stray and dropped. Writes report zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= ZeroWord;
        end else if ((state_r == ST_WAIT) && mem_resp_valid) begin
            if (wen_r) begin
                rdata_r <= ZeroWord;
            end else begin
                rdata_r <= mem_rdata;
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule
